// File: rtl/se_seq.sv
// se_seq: multi-sector erase sequencer that issues one sector erase per sector and polls RDSR/WIP until each erase finishes.
//
// Ports:
//   sclk, rst_n                     clock, synchronous active-low reset
//   start, first_sec, sec_num       request, first sector and count (sampled in IDLE only)
//   busy, done, err, cur_sec        sequence status
//   se_start, se_addr, se_end       handshake with the sector-erase engine
//   se_cs_n, se_sck, se_sdi         erase engine flash pins
//   cs_n, sck, sdi, sdo             flash pins (erase engine pins in ERASE, poll shifter otherwise)
module se_seq #(
    parameter int          POLL_GAP = 1000,
    parameter logic [15:0] MAX_POLL = 16'd50000
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] first_sec,
    input  logic [7:0] sec_num,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] cur_sec,
    output logic       se_start,
    output logic [7:0] se_addr,
    input  logic       se_end,
    input  logic       se_cs_n,
    input  logic       se_sck,
    input  logic       se_sdi,
    output logic       cs_n,
    output logic       sck,
    output logic       sdi,
    input  logic       sdo
);
    localparam int         GW   = $clog2(POLL_GAP + 1);
    localparam logic [7:0] RDSR = 8'h05;

    typedef enum logic [2:0] {IDLE, ERASE, GAP, POLL, CHECK, FIN} state_t;

    state_t        state, nxt;
    logic [7:0]    rem, cur_sec_nxt;
    logic [15:0]   poll_cnt;
    logic [GW-1:0] gap_cnt;
    logic [6:0]    pc;
    logic          wip, timeout, p_cs_n, p_sck, p_sdi;
    logic          accept, gap_done, frame_end, poll_more, in_bits, enter_erase;

    assign accept      = state == IDLE && start;
    assign gap_done    = gap_cnt == GW'(POLL_GAP - 1);
    assign frame_end   = pc == 7'd65;
    assign poll_more   = poll_cnt + 16'd1 < MAX_POLL;
    // pc counts frame cycles: 0 is the cs_n lead-in, 1..64 are 16 bits x 4 phases, 65 is the cs_n tail
    assign in_bits     = state == POLL && pc < 7'd64;
    assign enter_erase = nxt == ERASE && state != ERASE;
    assign cur_sec_nxt = accept ? first_sec : (state == CHECK && nxt == ERASE) ? cur_sec + 8'd1 : cur_sec;

    always_ff @(posedge sclk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = (sec_num == 8'd0) ? FIN : ERASE;
            ERASE:   if (se_end) nxt = GAP;
            GAP:     if (gap_done) nxt = POLL;
            POLL:    if (frame_end) nxt = CHECK;
            CHECK:   nxt = wip ? (poll_more ? GAP : FIN) : (rem == 8'd1 ? FIN : ERASE);
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // The erase engine owns the pins only while its command is in flight
    always_comb begin
        cs_n = state == ERASE ? se_cs_n : p_cs_n;
        sck  = state == ERASE ? se_sck  : p_sck;
        sdi  = state == ERASE ? se_sdi  : p_sdi;
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cur_sec  <= 8'd0;
            se_start <= 1'b0;
            se_addr  <= 8'd0;
            rem      <= 8'd0;
            poll_cnt <= 16'd0;
            gap_cnt  <= '0;
            pc       <= 7'd0;
            wip      <= 1'b0;
            timeout  <= 1'b0;
            p_cs_n   <= 1'b1;
            p_sck    <= 1'b0;
            p_sdi    <= 1'b0;
        end else begin
            done     <= state == FIN;
            busy     <= accept | (busy & ~done);
            err      <= accept ? 1'b0 : (state == FIN) ? timeout : err;
            se_start <= enter_erase;
            cur_sec  <= cur_sec_nxt;
            if (enter_erase)
                se_addr <= cur_sec_nxt;
            if (accept) begin
                rem     <= sec_num;
                timeout <= 1'b0;
            end else if (state == CHECK && !wip) begin
                rem <= rem - 8'd1;
            end
            if (state == CHECK && wip && !poll_more)
                timeout <= 1'b1;
            poll_cnt <= (state == ERASE && se_end) ? 16'd0 :
                        (state == CHECK && wip && poll_more) ? poll_cnt + 16'd1 : poll_cnt;
            gap_cnt  <= state == GAP ? gap_cnt + GW'(1) : '0;
            pc       <= state == POLL ? pc + 7'd1 : 7'd0;
            // Only WIP (status bit 0, the last read bit) steers the sequence; it is taken at phase 2 of bit 15
            if (state == POLL && pc == 7'd63)
                wip <= sdo;
            // Pin registers are loaded with the value for the next frame cycle
            p_cs_n <= !(state == GAP && gap_done) && !in_bits;
            p_sck  <= in_bits && pc[1];
            p_sdi  <= in_bits && !pc[5] && RDSR[~pc[4:2]];
        end
    end
endmodule

// File: doc/se_seq.md
# se_seq

Multi-sector erase sequencer for the multiboot SPI flash path. Given a first sector and a sector count, it triggers the sector-erase engine once per sector. After each erase command it polls the flash status register (RDSR, WIP bit) over its own SPI shifter until the erase completes, then advances to the next sector. It owns the flash pins and multiplexes them between the erase engine and its own poll logic.

## Interface
Parameters:
- POLL_GAP, 1000: idle sclk cycles between consecutive RDSR polls (cs_n high).
- MAX_POLL, 16'd50000: polls allowed per sector before timeout error.

Ports:
- sclk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- first_sec  in  8  first sector address (ADDR1 byte), sampled with start.
- sec_num  in  8  number of sectors to erase, sampled with start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of sequence (success or error).
- err  out  1  timeout flag; set with done, cleared on next accepted start.
- cur_sec  out  8  sector currently being erased or polled.
- se_start  out  1  one-cycle pulse to erase engine.
- se_addr  out  8  sector address to erase engine; valid and stable while se_start is high and until se_end.
- se_end  in  1  one-cycle completion pulse from erase engine.
- se_cs_n, se_sck, se_sdi  in  1 each  erase engine flash pins.
- cs_n, sck, sdi  out  1 each  flash pins.
- sdo  in  1  flash serial data out.

## Operation
- States: IDLE, ERASE, GAP, POLL, CHECK, FIN.
- IDLE: on start=1, latch first_sec into cur_sec and sec_num into a remaining counter. If sec_num=0, go to FIN. Otherwise go to ERASE. start is ignored outside IDLE.
- ERASE: se_start is high for the first cycle in state, with se_addr=cur_sec. Wait for se_end, then clear poll_cnt and go to GAP.
- GAP: count POLL_GAP cycles, then go to POLL.
- POLL: one RDSR transaction.
  - Instruction 8'h05 is sent MSB first, followed by 8 read bits.
  - Each bit lasts 4 sclk, phases 0–3.
  - sck=0 in phases 0–1 and sck=1 in phases 2–3.
  - sdi updates at phase 0.
  - sdo is sampled at phase 2 of read bits into status[7:0], MSB first.
  - Frame: cs_n falls one cycle before the first bit phase 0, and rises one cycle after the last bit phase 3. Total frame is 66 cycles.
  - During the read bits, sdi=0.
- CHECK: one cycle.
  - If status[0]=1 and poll_cnt+1 < MAX_POLL: increment poll_cnt, go to GAP.
  - If status[0]=1 and poll_cnt+1 = MAX_POLL: set err, go to FIN.
  - If status[0]=0: decrement remaining. If remaining becomes 0, go to FIN. Otherwise cur_sec <= cur_sec+1 (mod 256, 8'hFF wraps to 8'h00) and go to ERASE.
- FIN: done=1 for one cycle, busy drops, go to IDLE.
- Pin mux: in ERASE, {cs_n,sck,sdi} = {se_cs_n,se_sck,se_sdi}. In all other states they are driven by the internal poll registers. Outside the POLL frame, the poll registers hold cs_n=1, sck=0, sdi=0.
- A se_end outside ERASE is ignored.

## Timing
- Reset values: busy=0, done=0, err=0, cur_sec=0, se_start=0, se_addr=0, cs_n=1, sck=0, sdi=0, state=IDLE.
- Reset mid-sequence aborts immediately: the next cycle shows the reset values, and no done pulse is issued.
- start at cycle T:
  - busy=1 and se_start=1 at T+1.
  - For sec_num=0, done=1 at T+2 and busy=0 at T+3.
- se_end at cycle E: GAP is entered at E+1, and cs_n falls at E+1+POLL_GAP.
- done asserts the cycle after the final CHECK. err is stable at that same cycle.
- All outputs are registered except the pin mux, which is a combinational select driven by the registered state.

## Test plan
- start, first_sec=8'h40, sec_num=1. Flash model reports WIP=1 for 3 polls, then 0. Require one se_start with se_addr=8'h40, 4 RDSR frames each sdi pattern 8'h05, done with err=0.
- sec_num=3, first_sec=8'hFE, WIP clears on first poll. Require se_addr sequence FE, FF, 00; done after the third CHECK; cur_sec=8'h00.
- MAX_POLL=4, WIP stuck at 1. Require exactly 4 polls, then done=1 and err=1, with no second se_start. The next start clears err.
- sec_num=0. Require done at T+2, no se_start, and cs_n held at 1.
- start pulsed while busy, plus a spurious se_end during GAP. Both must be ignored, and the sequence completes unchanged.
- rst_n=0 during a POLL frame. Require cs_n=1, sck=0, busy=0 the next cycle and no done pulse. A subsequent start then works normally.
